// File: rtl/note_stepper.sv
// Per-voice phase generator: fetches the step size for a note from the step ROM, accumulates phase per sample
// request and counts beats down to the end of the note. Optional OCTAVE_UP_EN doubles the captured step.
module note_stepper #(
  parameter int DUR_W  = 6,
  parameter int STEP_W = 20,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              play_enable,
  input  logic              load_new_note,
  input  logic [5:0]        note,
  input  logic [DUR_W-1:0]  duration,
`ifdef OCTAVE_UP_EN
  input  logic              octave_up,
`endif
  input  logic              beat,
  input  logic              generate_next_sample,
  output logic [5:0]        rom_addr,
  input  logic [STEP_W-1:0] step_size,
  output logic [ADDR_W-1:0] sample_addr,
  output logic              sample_addr_valid,
  output logic              done_with_note,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, RUN} state_t;

  state_t              state_q;
  logic [5:0]          rom_addr_q;
  logic [DUR_W-1:0]    remaining_q;
  logic [STEP_W-1:0]   step_q;
  logic [STEP_W-1:0]   phase_q;
  logic [ADDR_W-1:0]   sample_addr_q;
  logic                valid_q;
  logic                done_q;
  logic [STEP_W-1:0]   phase_d;
  logic [STEP_W-1:0]   step_d;

  // Accumulator wraps naturally at 2^STEP_W.
  assign phase_d = phase_q + step_q;

`ifdef OCTAVE_UP_EN
  logic oct_q;
  assign step_d = oct_q ? {step_size[STEP_W-2:0], 1'b0} : step_size;
`else
  assign step_d = step_size;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rom_addr_q    <= '0;
      remaining_q   <= '0;
      step_q        <= '0;
      phase_q       <= '0;
      sample_addr_q <= '0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
`ifdef OCTAVE_UP_EN
      oct_q         <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      // A new load overrides whatever the current note was doing, silently.
      if (load_new_note) begin
        rom_addr_q  <= note;
        remaining_q <= duration;
        state_q     <= FETCH;
`ifdef OCTAVE_UP_EN
        oct_q       <= octave_up;
`endif
      end else begin
        case (state_q)
          FETCH: state_q <= WAIT;
          WAIT: begin
            step_q  <= step_d;
            phase_q <= '0;
            if (remaining_q == '0) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= RUN;
            end
          end
          RUN: begin
            if (play_enable) begin
              if (generate_next_sample) begin
                phase_q       <= phase_d;
                sample_addr_q <= phase_d[STEP_W-1 -: ADDR_W];
                valid_q       <= 1'b1;
              end
              if (beat) begin
                remaining_q <= remaining_q - DUR_W'(1);
                if (remaining_q == DUR_W'(1)) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
                end
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rom_addr          = rom_addr_q;
  assign sample_addr       = sample_addr_q;
  assign sample_addr_valid = valid_q;
  assign done_with_note    = done_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_note_stepper.sv
// Scoreboard bench for note_stepper with a registered step-ROM stub.
module tb_note_stepper;

  logic        clk;
  logic        reset_n;
  logic        play_enable;
  logic        load_new_note;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        octave_up;
  logic        beat;
  logic        generate_next_sample;
  logic [5:0]  rom_addr;
  logic [19:0] step_size;
  logic [9:0]  sample_addr;
  logic        sample_addr_valid;
  logic        done_with_note;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [9:0]  exp_q[$];
  logic [19:0] m_phase;
  logic [19:0] m_step;
  logic [5:0]  m_rem;
  logic        m_run;
  logic [9:0]  m_last;

  note_stepper #(.DUR_W(6), .STEP_W(20), .ADDR_W(10)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .play_enable         (play_enable),
    .load_new_note       (load_new_note),
    .note                (note),
    .duration            (duration),
`ifdef OCTAVE_UP_EN
    .octave_up           (octave_up),
`endif
    .beat                (beat),
    .generate_next_sample(generate_next_sample),
    .rom_addr            (rom_addr),
    .step_size           (step_size),
    .sample_addr         (sample_addr),
    .sample_addr_valid   (sample_addr_valid),
    .done_with_note      (done_with_note),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] rom_fn(input logic [5:0] n);
    case (n)
      6'd0:    rom_fn = 20'd0;
      6'd37:   rom_fn = 20'd76895;
      6'd63:   rom_fn = 20'd346030;
      default: rom_fn = {4'd0, n, 10'd0};
    endcase
  endfunction

  always @(posedge clk) step_size <= rom_fn(rom_addr);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sample_addr_valid) begin
      if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
      else check("sample_addr", {22'd0, sample_addr}, {22'd0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_note(input logic [5:0] n, input logic [5:0] d, input logic o);
    note = n; duration = d; octave_up = o; load_new_note = 1'b1;
    tick();
    load_new_note = 1'b0;
    m_run = 1'b0;
    check("ld_rom_addr", {26'd0, rom_addr}, {26'd0, n});
    check("ld_done", {31'd0, done_with_note}, 32'd0);
    check("ld_busy", {31'd0, busy}, 32'd1);
    tick();
    check("fetch_done", {31'd0, done_with_note}, 32'd0);
    check("fetch_busy", {31'd0, busy}, 32'd1);
    tick();
    m_step = rom_fn(n);
`ifdef OCTAVE_UP_EN
    if (o) m_step = m_step << 1;
`endif
    m_phase = 20'd0;
    m_rem   = d;
    m_run   = (d != 6'd0);
    check("wait_done", {31'd0, done_with_note}, {31'd0, d == 6'd0});
    check("wait_busy", {31'd0, busy}, {31'd0, m_run});
  endtask

  task automatic cycle(input logic g, input logic b);
    logic exp_done;
    exp_done = 1'b0;
    generate_next_sample = g;
    beat = b;
    if (m_run && play_enable) begin
      if (g) begin
        m_phase = m_phase + m_step;
        m_last  = m_phase[19:10];
        exp_q.push_back(m_last);
      end
      if (b) begin
        if (m_rem == 6'd1) begin
          exp_done = 1'b1;
          m_run    = 1'b0;
        end
        m_rem = m_rem - 6'd1;
      end
    end
    tick();
    generate_next_sample = 1'b0;
    beat = 1'b0;
    check("done", {31'd0, done_with_note}, {31'd0, exp_done});
    check("busy", {31'd0, busy}, {31'd0, m_run});
  endtask

  initial begin
    reset_n = 1'b0; play_enable = 1'b1; load_new_note = 1'b0; note = '0; duration = '0;
    octave_up = 1'b0; beat = 1'b0; generate_next_sample = 1'b0;
    m_phase = '0; m_step = '0; m_rem = '0; m_run = 1'b0; m_last = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rom_addr", {26'd0, rom_addr}, 32'd0);
    check("rst_sample_addr", {22'd0, sample_addr}, 32'd0);
    check("rst_valid", {31'd0, sample_addr_valid}, 32'd0);
    check("rst_done", {31'd0, done_with_note}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    tick();

    // Note 37: first request right after the load sequence lands at edge k+3.
    load_note(6'd37, 6'd4, 1'b0);
    cycle(1'b1, 1'b0);
    check("first_valid", {31'd0, sample_addr_valid}, 32'd1);
    check("first_addr", {22'd0, sample_addr}, 32'd75);
    cycle(1'b1, 1'b0);
    check("second_addr", {22'd0, sample_addr}, 32'd150);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
    end

    // Note 63: wrap on the fourth request.
    load_note(6'd63, 6'd2, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
    check("wrap_addr", {22'd0, sample_addr}, 32'd327);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);

    // Duration 3, irregular beats, last beat together with a sample.
    load_note(6'd37, 6'd3, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    check("final_valid", {31'd0, sample_addr_valid}, 32'd1);
    cycle(1'b1, 1'b1);
    check("idle_hold_addr", {22'd0, sample_addr}, {22'd0, m_last});

    // Pause in RUN: nothing moves for 10 cycles.
    load_note(6'd63, 6'd2, 1'b0);
    cycle(1'b1, 1'b0);
    play_enable = 1'b0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1);
    play_enable = 1'b1;
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);

    // Rest note and zero duration.
    load_note(6'd0, 6'd1, 1'b0);
    cycle(1'b1, 1'b0);
    check("rest_addr", {22'd0, sample_addr}, 32'd0);
    cycle(1'b0, 1'b1);
    load_note(6'd5, 6'd0, 1'b0);
    cycle(1'b1, 1'b1);

    // Restart mid-note, then asynchronous reset mid-note.
    load_note(6'd37, 6'd5, 1'b0);
    cycle(1'b1, 1'b1);
    load_note(6'd63, 6'd5, 1'b0);
    cycle(1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_rom_addr", {26'd0, rom_addr}, 32'd0);
    check("arst_sample_addr", {22'd0, sample_addr}, 32'd0);
    check("arst_valid", {31'd0, sample_addr_valid}, 32'd0);
    check("arst_done", {31'd0, done_with_note}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    m_run = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    cycle(1'b1, 1'b1);

`ifdef OCTAVE_UP_EN
    load_note(6'd37, 6'd1, 1'b1);
    cycle(1'b1, 1'b0);
    check("octave_addr", {22'd0, sample_addr}, 32'd150);
    cycle(1'b0, 1'b1);
`endif

    repeat (2) tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
